// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out serializer: captures a WIDTH-bit word on load and
// emits it MSB first, one bit per clock, with a busy flag while bits remain.
module piso_shift_register #(
    parameter int   WIDTH = 4,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (load) begin
            shift_d = parallel_in;
            count_d = CNT_W'(WIDTH);
        end else begin
            // Shifting never stops; the counter alone tracks the loaded bits
            shift_d = {shift_q[WIDTH-2:0], FILL};
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    assign serial_out = shift_q[WIDTH-1];
    assign busy       = (count_q != '0);

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench for piso_shift_register: a WIDTH=4/FILL=0 instance and a
// WIDTH=8/FILL=1 instance, directed vectors with hand-computed expectations.
module tb_piso_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld4, ld8;
    logic [3:0] pi4;
    logic [7:0] pi8;
    logic       so4, busy4, so8, busy8;

    typedef struct {
        int    dsel;
        logic  eso;
        logic  ebusy;
        string nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    piso_shift_register #(.WIDTH(4), .FILL(1'b0)) dut4 (
        .clk(clk), .rst(rst), .load(ld4), .parallel_in(pi4),
        .serial_out(so4), .busy(busy4)
    );

    piso_shift_register #(.WIDTH(8), .FILL(1'b1)) dut8 (
        .clk(clk), .rst(rst), .load(ld8), .parallel_in(pi8),
        .serial_out(so8), .busy(busy8)
    );

    // Monitor: pops expectations and compares away from the active edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            logic aso, ab;
            e   = sb.pop_front();
            aso = (e.dsel == 8) ? so8 : so4;
            ab  = (e.dsel == 8) ? busy8 : busy4;
            checks++;
            if (aso !== e.eso) begin
                errors++;
                $display("FAIL %s serial_out: got %b want %b", e.nm, aso, e.eso);
            end
            checks++;
            if (ab !== e.ebusy) begin
                errors++;
                $display("FAIL %s busy: got %b want %b", e.nm, ab, e.ebusy);
            end
        end
    end

    task automatic step4(input logic r, input logic l, input logic [3:0] d,
                         input logic eso, input logic eb, input string nm);
        rst = r; ld4 = l; pi4 = d; ld8 = 1'b0; pi8 = 8'h00;
        @(posedge clk);
        #1;
        sb.push_back('{4, eso, eb, nm});
    endtask

    task automatic step8(input logic r, input logic l, input logic [7:0] d,
                         input logic eso, input logic eb, input string nm);
        rst = r; ld8 = l; pi8 = d; ld4 = 1'b0; pi4 = 4'h0;
        @(posedge clk);
        #1;
        sb.push_back('{8, eso, eb, nm});
    endtask

    initial begin
        rst = 1'b1; ld4 = 1'b0; ld8 = 1'b0; pi4 = 4'h0; pi8 = 8'h00;
        @(negedge clk);

        // Reset with simultaneous load: reset wins
        step4(1, 1, 4'b1111, 0, 0, "reset");
        step8(1, 1, 8'hFF, 0, 0, "reset8");

        // Basic serialize 1011; parallel_in garbage while not loading
        step4(0, 1, 4'b1011, 1, 1, "basic_b0");
        step4(0, 0, 4'b1111, 0, 1, "basic_b1");
        step4(0, 0, 4'b1111, 1, 1, "basic_b2");
        step4(0, 0, 4'b0101, 1, 1, "basic_b3");
        step4(0, 0, 4'b1111, 0, 0, "basic_fill1");
        step4(0, 0, 4'b1111, 0, 0, "basic_fill2");

        // Reload mid-word
        step4(0, 1, 4'b1011, 1, 1, "reload_a0");
        step4(0, 0, 4'b0000, 0, 1, "reload_a1");
        step4(0, 1, 4'b0110, 0, 1, "reload_b0");
        step4(0, 0, 4'b0000, 1, 1, "reload_b1");
        step4(0, 0, 4'b0000, 1, 1, "reload_b2");
        step4(0, 0, 4'b0000, 0, 1, "reload_b3");
        step4(0, 0, 4'b0000, 0, 0, "reload_done");

        // Gapless stream: second load on the edge busy would fall
        step4(0, 1, 4'b1100, 1, 1, "gap_a0");
        step4(0, 0, 4'b0000, 1, 1, "gap_a1");
        step4(0, 0, 4'b0000, 0, 1, "gap_a2");
        step4(0, 0, 4'b0000, 0, 1, "gap_a3");
        step4(0, 1, 4'b0011, 0, 1, "gap_b0");
        step4(0, 0, 4'b0000, 0, 1, "gap_b1");
        step4(0, 0, 4'b0000, 1, 1, "gap_b2");
        step4(0, 0, 4'b0000, 1, 1, "gap_b3");
        step4(0, 0, 4'b0000, 0, 0, "gap_done");

        // Reset mid-shift
        step4(0, 1, 4'b1111, 1, 1, "rstmid_b0");
        step4(0, 0, 4'b0000, 1, 1, "rstmid_b1");
        step4(0, 0, 4'b0000, 1, 1, "rstmid_b2");
        step4(1, 0, 4'b0000, 0, 0, "rstmid_rst");
        step4(0, 0, 4'b0000, 0, 0, "rstmid_after1");
        step4(0, 0, 4'b0000, 0, 0, "rstmid_after2");
        step4(0, 0, 4'b0000, 0, 0, "rstmid_after3");

        // WIDTH=8, FILL=1: A5 then ones; busy high for 8 cycles
        step8(0, 1, 8'hA5, 1, 1, "w8_b0");
        step8(0, 0, 8'h00, 0, 1, "w8_b1");
        step8(0, 0, 8'h00, 1, 1, "w8_b2");
        step8(0, 0, 8'h00, 0, 1, "w8_b3");
        step8(0, 0, 8'h00, 0, 1, "w8_b4");
        step8(0, 0, 8'h00, 1, 1, "w8_b5");
        step8(0, 0, 8'h00, 0, 1, "w8_b6");
        step8(0, 0, 8'h00, 1, 1, "w8_b7");
        step8(0, 0, 8'h00, 1, 0, "w8_fill1");
        step8(0, 0, 8'h00, 1, 0, "w8_fill2");
        step8(0, 0, 8'h00, 1, 0, "w8_fill3");

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
